score_ascii_conv: RTL
=====================

Name: score_ascii_conv

Overview:
Parametrised sequential converter that turns two binary player scores into packed 7-bit ASCII decimal strings and a winner code. It replaces the constant score and winner codes currently fed to the score-screen character ROM in the SCORE state. It runs in the pixel clock domain, between score_counter (plus the opponent score link) and char_rom_score. Conversion is multi-cycle shift-add-3 (double dabble), with both players converted in parallel.

Parameters:
SCORE_W, 16, width of each binary score input (>=2)
DIGITS, 5, number of decimal digits produced per player (>=1)
BLANK_LZ, 0, 1 = leading zeros rendered as space 7'h20 (least significant digit always shown); 0 = rendered as '0'
TIE_CODE, 7'h30, ASCII code output on winner_ascii when scores are equal

Ports:
pclk  input  1  pixel clock; all logic is on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a conversion; sampled only in IDLE
my_score  input  SCORE_W  local player binary score
op_score  input  SCORE_W  opponent binary score
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when results update
my_ascii  output  7*DIGITS  local score digits; digit 0 (units) in [6:0]
op_ascii  output  7*DIGITS  opponent score digits, same packing
my_ovf  output  1  local score exceeds 10^DIGITS-1; string is saturated
op_ovf  output  1  opponent overflow, same rule
winner_ascii  output  7  7'h31 local wins, 7'h32 opponent wins, TIE_CODE on a tie

Behaviour:
- Reset (synchronous, takes priority over everything):
  - FSM goes to IDLE; busy=0; done=0.
  - my_ascii and op_ascii: every digit 7'h30, regardless of BLANK_LZ.
  - my_ovf=op_ovf=0; winner_ascii=TIE_CODE.
  - Internal shift and BCD registers are cleared.
- FSM states are IDLE, CONV and FINISH.
- IDLE:
  - On start=1, capture my_score and op_score into shift registers, clear both BCD registers (4*DIGITS bits each), clear the overflow accumulators, load the step counter with SCORE_W, and go to CONV.
  - The winner comparison uses the captured values.
- CONV: one double-dabble step per cycle, for both channels.
  - Add 3 to every BCD digit >=5.
  - Shift {bcd, bin} left by 1.
  - If the bit shifted out of the top BCD digit is 1, set that channel's overflow accumulator. This is exact detection of value >= 10^DIGITS.
  - Decrement the counter; after SCORE_W steps go to FINISH.
- FINISH (one cycle):
  - Register all outputs and assert done=1 for exactly this cycle; then go to IDLE.
  - Each digit maps to {3'b011, bcd_digit}.
  - An overflowed channel outputs 7'h39 in every digit and sets its ovf bit.
  - With BLANK_LZ=1, each zero digit above the highest nonzero digit becomes 7'h20. An all-zero value gives spaces plus a units '0'. Blanking does not apply to an overflowed channel.
  - winner_ascii: captured my > op gives 7'h31; op > my gives 7'h32; equal gives TIE_CODE. The comparison is on the full binary values, independent of overflow.
- busy=1 in CONV and FINISH.
- Latency: start in cycle 0 gives busy in cycles 1..SCORE_W+1 and done in cycle SCORE_W+1. The next start is accepted in cycle SCORE_W+2, so the minimum period is SCORE_W+2 cycles.
- start while busy (CONV or FINISH) is ignored and not queued. Score inputs may change freely after the capture cycle.
- Outputs hold their previous values between done pulses; all result outputs change only in the done cycle, never partially.
- Reset asserted mid-CONV or during FINISH aborts the conversion. No done pulse occurs and outputs take their reset values on the next edge.
- start and rst high together: reset wins and the start is dropped.
- Zero score converts normally: BLANK_LZ=0 gives "0...0"; BLANK_LZ=1 gives spaces plus '0'.

Test Plan:
1. Defaults; my=12345, op=678, start for 1 cycle -> done exactly in cycle 17. my_ascii={35,34,33,32,31} in units-first order, i.e. "12345". op_ascii "00678" = 30 30 36 37 38. winner=7'h31. busy high cycles 1-17.
2. BLANK_LZ=1; my=0, op=678 -> my_ascii "    0" (20 20 20 20 30), op_ascii "  678". winner=7'h32.
3. DIGITS=3, SCORE_W=16; my=1000, op=999 -> my_ascii "999", my_ovf=1. op_ascii "999", op_ovf=0. winner=7'h31.
4. my=op=42 -> winner=TIE_CODE (7'h30). A second start pulse in cycle 5 of the conversion is ignored: one done only, in cycle 17, and busy low in cycle 18.
5. Reset mid-conversion: start with my=500; assert rst at cycle 8 -> no done, busy=0, all digits 7'h30, winner=7'h30. A new start after reset converts correctly to "00500".
6. Back-to-back: start at cycles 0 and 18 with different scores -> done at cycles 17 and 35. Each result is held stable between the pulses.

Source files
------------

// File: rtl/score_ascii_conv_if.sv
// Handshake and result bundle between the score sources and the score-screen character ROM.
// One instance per converter; widths follow the converter's SCORE_W and DIGITS.
interface score_ascii_conv_if #(
    parameter int SCORE_W = 16,
    parameter int DIGITS  = 5
);
    logic                  start;
    logic [SCORE_W-1:0]    my_score;
    logic [SCORE_W-1:0]    op_score;
    logic                  busy;
    logic                  done;
    logic [7*DIGITS-1:0]   my_ascii;
    logic [7*DIGITS-1:0]   op_ascii;
    logic                  my_ovf;
    logic                  op_ovf;
    logic [6:0]            winner_ascii;

    modport master (
        output start, my_score, op_score,
        input  busy, done, my_ascii, op_ascii, my_ovf, op_ovf, winner_ascii
    );

    modport slave (
        input  start, my_score, op_score,
        output busy, done, my_ascii, op_ascii, my_ovf, op_ovf, winner_ascii
    );
endinterface

// File: rtl/score_ascii_conv.sv
// Converts two binary scores to packed 7-bit ASCII decimal strings plus a winner code.
// Both channels run one shift-add-3 (double dabble) step per cycle in parallel.
module score_ascii_conv #(
    parameter int         SCORE_W  = 16,
    parameter int         DIGITS   = 5,
    parameter bit         BLANK_LZ = 1'b0,
    parameter logic [6:0] TIE_CODE = 7'h30
) (
    input logic               pclk,
    input logic               rst,
    score_ascii_conv_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int STR_W = 7 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [STR_W-1:0] ZERO_STR = {DIGITS{7'h30}};

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;

    logic [SCORE_W-1:0] my_bin, op_bin, my_bin_nx, op_bin_nx;
    logic [BCD_W-1:0]   my_bcd, op_bcd, my_bcd_nx, op_bcd_nx;
    logic               my_carry, op_carry;
    logic               my_acc, op_acc;
    logic [6:0]         win_cap;

    logic [STR_W-1:0]   my_str, op_str;
    logic               my_ovf_q, op_ovf_q;
    logic [6:0]         win_q;
    logic               busy_c, done_c;

    // Returns {carry_out, bcd_next, bin_next} for one double-dabble step.
    function automatic logic [BCD_W+SCORE_W:0] dd_step(input logic [BCD_W-1:0]   bcd,
                                                       input logic [SCORE_W-1:0] bin);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
        return {adj, bin, 1'b0};
    endfunction

    function automatic logic [STR_W-1:0] fmt(input logic [BCD_W-1:0] bcd, input logic ovf);
        logic [STR_W-1:0] s;
        logic             lead;
        s    = '0;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (ovf) begin
                s[7*d +: 7] = 7'h39;
            end else if (BLANK_LZ && lead && (d != 0) && (bcd[4*d +: 4] == 4'd0)) begin
                s[7*d +: 7] = 7'h20;
            end else begin
                s[7*d +: 7] = {3'b011, bcd[4*d +: 4]};
                lead        = 1'b0;
            end
        end
        return s;
    endfunction

    assign {my_carry, my_bcd_nx, my_bin_nx} = dd_step(my_bcd, my_bin);
    assign {op_carry, op_bcd_nx, op_bin_nx} = dd_step(op_bcd, op_bin);
    assign last_step = (cnt == CNT_W'(1));

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE:   if (bus.start) state_nx = CONV;
            CONV: begin
                busy_c = 1'b1;
                if (last_step) state_nx = FINISH;
            end
            FINISH: begin
                busy_c   = 1'b1;
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Results are loaded on the edge into FINISH so they are valid during the done cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt      <= '0;
            my_bin   <= '0;
            op_bin   <= '0;
            my_bcd   <= '0;
            op_bcd   <= '0;
            my_acc   <= 1'b0;
            op_acc   <= 1'b0;
            win_cap  <= TIE_CODE;
            my_str   <= ZERO_STR;
            op_str   <= ZERO_STR;
            my_ovf_q <= 1'b0;
            op_ovf_q <= 1'b0;
            win_q    <= TIE_CODE;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    my_bin  <= bus.my_score;
                    op_bin  <= bus.op_score;
                    my_bcd  <= '0;
                    op_bcd  <= '0;
                    my_acc  <= 1'b0;
                    op_acc  <= 1'b0;
                    cnt     <= CNT_W'(SCORE_W);
                    if (bus.my_score > bus.op_score)      win_cap <= 7'h31;
                    else if (bus.op_score > bus.my_score) win_cap <= 7'h32;
                    else                                  win_cap <= TIE_CODE;
                end
                CONV: begin
                    my_bin <= my_bin_nx;
                    op_bin <= op_bin_nx;
                    my_bcd <= my_bcd_nx;
                    op_bcd <= op_bcd_nx;
                    my_acc <= my_acc | my_carry;
                    op_acc <= op_acc | op_carry;
                    cnt    <= cnt - CNT_W'(1);
                    if (last_step) begin
                        my_str   <= fmt(my_bcd_nx, my_acc | my_carry);
                        op_str   <= fmt(op_bcd_nx, op_acc | op_carry);
                        my_ovf_q <= my_acc | my_carry;
                        op_ovf_q <= op_acc | op_carry;
                        win_q    <= win_cap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
    assign bus.my_ascii     = my_str;
    assign bus.op_ascii     = op_str;
    assign bus.my_ovf       = my_ovf_q;
    assign bus.op_ovf       = op_ovf_q;
    assign bus.winner_ascii = win_q;
endmodule
